// File: rtl/sublime_dpram_clr.sv
// sublime_dpram_clr: simple dual-port RAM, one write port and one synchronous
// read port on a single clock. Provides byte-enable writes, selectable
// read-during-write behaviour, an optional output register stage, a read-valid
// strobe, and a clear sequencer that fills the whole array with CLEAR_VALUE.
module sublime_dpram_clr #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int BYPASS         = 1,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output logic                  busy,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [BE_WIDTH-1:0]   wbe,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;

  assign busy    = (state_q == CLEAR);
  assign rd_fire = re && !busy;

  // Clear sequencer state and address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: start on clear request, leave after the last address is written
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Array write port: the sequencer owns it while busy, else byte-lane user writes
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt_q[ADDR_WIDTH-1:0]] <= CLEAR_VALUE;
    end else if (we) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  // Read word, with same-address write lanes merged in when bypass is selected
  always_comb begin
    rd_word = mem[raddr];
    if ((BYPASS != 0) && we && (raddr == waddr)) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (wbe[i]) rd_word[8*i +: 8] = din[8*i +: 8];
      end
    end
  end

  // First read stage: capture on accepted read, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_fire;
      if (rd_fire) rdata_q <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  dvalid_q;

      // Second read stage; reads already in flight complete even while busy
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q   <= '0;
          dvalid_q <= 1'b0;
        end else begin
          dvalid_q <= rvalid_q;
          if (rvalid_q) dout_q <= rdata_q;
        end
      end

      assign dout       = dout_q;
      assign dout_valid = dvalid_q;
    end else begin : g_no_out_reg
      assign dout       = rdata_q;
      assign dout_valid = rvalid_q;
    end
  endgenerate

endmodule
